// File: rtl/high_pass_ve_pkg.sv
// Shared types and helpers for the high-pass filter stage.
package high_pass_ve_pkg;

    // Filter control states; encodings match the low-pass stage.
    typedef enum logic [1:0] {
        StPreload = 2'd0,
        StSettle  = 2'd1,
        StRun     = 2'd2
    } hp_state_e;

    localparam int unsigned DefWidth     = 16;
    localparam int unsigned DefFrac      = 16;
    localparam int unsigned DefSettleLen = 16;

    // Accumulator width: sample bits, guard bits, plus one headroom bit.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned frac);
        return width + frac + 1;
    endfunction

endpackage

// File: rtl/high_pass_ve_sat.sv
// Combinational signed clamp from IN_W to OUT_W bits, shared by the filter blocks.
module sat_signed #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o
);

    localparam logic signed [IN_W-1:0] MaxVal = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MinVal = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Clamp to the representable OUT_W range instead of wrapping.
    always_comb begin
        out_o = in_i[OUT_W-1:0];
        if (in_i > MaxVal) begin
            out_o = MaxVal[OUT_W-1:0];
        end else if (in_i < MinVal) begin
            out_o = MinVal[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/high_pass_ve.sv
// First-order IIR high-pass: y = x - lp(x), with preload/settle control and a settled flag.
module high_pass_ve
    import high_pass_ve_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned FRAC       = DefFrac,
    parameter int unsigned SETTLE_LEN = DefSettleLen
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic signed [WIDTH-1:0] data_i,
    input  logic                    valid_i,
    input  logic        [WIDTH-1:0] cutoff_i,
    output logic signed [WIDTH-1:0] out_o,
    output logic                    valid_o,
    output logic                    settled_o
);

    localparam int unsigned AccW  = acc_width(WIDTH, FRAC);
    localparam int unsigned LpW   = WIDTH + 1;
    localparam int unsigned DW    = WIDTH + 2;
    localparam int unsigned ProdW = DW + WIDTH + 1;
    localparam int unsigned ShW   = ProdW + FRAC;
    localparam int unsigned CntW  = $clog2(SETTLE_LEN + 1);

    hp_state_e               state_q, state_d;
    logic signed [AccW-1:0]  acc_q, acc_d;
    logic        [WIDTH-1:0] c_q, c_d;
    logic        [CntW-1:0]  cnt_q, cnt_d;
    logic signed [WIDTH-1:0] out_d;
    logic                    valid_d;
    logic                    settled_d;

    logic signed [LpW-1:0]   lp;
    logic signed [DW-1:0]    d;
    logic signed [WIDTH-1:0] d_sat;
    logic signed [ShW-1:0]   d_ext, c_ext, prod, shifted;

    // Low-pass estimate and difference; the bit slice of acc is a floor shift by FRAC.
    always_comb begin
        lp      = acc_q[AccW-1:FRAC];
        d       = {{2{data_i[WIDTH-1]}}, data_i} - {lp[LpW-1], lp};
        // A valid sample always filters with cutoff_i: it either equals c_q or replaces it.
        d_ext   = {{(ShW-DW){d[DW-1]}}, d};
        c_ext   = {{(ShW-WIDTH){1'b0}}, cutoff_i};
        prod    = d_ext * c_ext;
        shifted = (prod <<< FRAC) >>> WIDTH;
    end

    sat_signed #(
        .IN_W  (DW),
        .OUT_W (WIDTH)
    ) u_sat (
        .in_i  (d),
        .out_o (d_sat)
    );

    // Next-state, accumulator and output update; everything holds without a valid sample.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        out_d     = out_o;
        valid_d   = 1'b0;
        settled_d = settled_o;
        if (valid_i) begin
            valid_d = 1'b1;
            c_d     = cutoff_i;
            case (state_q)
                StPreload: begin
                    acc_d     = {data_i[WIDTH-1], data_i, {FRAC{1'b0}}};
                    out_d     = '0;
                    state_d   = StSettle;
                    cnt_d     = '0;
                    settled_d = 1'b0;
                end
                StSettle, StRun: begin
                    acc_d = acc_q + AccW'(shifted);
                    out_d = d_sat;
                    if (cutoff_i != c_q) begin
                        state_d   = StSettle;
                        cnt_d     = '0;
                        settled_d = 1'b0;
                    end else if (state_q == StSettle) begin
                        if (cnt_q == CntW'(SETTLE_LEN - 1)) begin
                            state_d   = StRun;
                            settled_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StPreload;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= StPreload;
            acc_q     <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            out_o     <= '0;
            valid_o   <= 1'b0;
            settled_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            out_o     <= out_d;
            valid_o   <= valid_d;
            settled_o <= settled_d;
        end
    end

`ifndef SYNTHESIS
    localparam logic signed [LpW-1:0] LpMax = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [LpW-1:0] LpMin = {2'b11, {(WIDTH-1){1'b0}}};

    // The low-pass estimate is bounded by the input range, so the accumulator never wraps.
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            assert (lp >= LpMin && lp <= LpMax);
        end
    end
`endif

endmodule

// File: tb/tb_high_pass_ve.sv
// Self-checking bench for high_pass_ve against an integer reference model.
module tb_high_pass_ve;

    localparam int W  = 16;
    localparam int F  = 16;
    localparam int SL = 16;

    logic                clk = 1'b0;
    logic                rstn;
    logic signed [W-1:0] data_i;
    logic                valid_i;
    logic        [W-1:0] cutoff_i;
    logic signed [W-1:0] out_o;
    logic                valid_o;
    logic                settled_o;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state: plain integers.
    bit     m_pre;
    bit     m_valid;
    bit     m_settled;
    int     m_cnt;
    int     m_c;
    int     m_out;
    longint m_acc;

    int ref_q[$];
    int got_q[$];

    always #5 clk = ~clk;

    high_pass_ve #(
        .WIDTH      (W),
        .FRAC       (F),
        .SETTLE_LEN (SL)
    ) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .cutoff_i  (cutoff_i),
        .out_o     (out_o),
        .valid_o   (valid_o),
        .settled_o (settled_o)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_reset();
        m_pre = 1; m_valid = 0; m_settled = 0; m_cnt = 0; m_c = 0; m_out = 0; m_acc = 0;
    endtask

    task automatic model_step(input bit v, input int x, input int c);
        longint lp, dd;
        m_valid = v;
        if (!v) return;
        if (m_pre) begin
            m_acc = longint'(x) * (64'sd1 << F);
            m_out = 0;
            m_c = c;
            m_pre = 0;
            m_cnt = 0;
            m_settled = 0;
            return;
        end
        lp = fdiv(m_acc, 64'sd1 << F);
        dd = longint'(x) - lp;
        m_acc = m_acc + fdiv(dd * longint'(c) * (64'sd1 << F), 64'sd1 << W);
        m_out = clamp(dd);
        if (c != m_c) begin
            m_c = c;
            m_cnt = 0;
            m_settled = 0;
        end else if (!m_settled) begin
            m_cnt++;
            if (m_cnt == SL) m_settled = 1;
        end
    endtask

    // One clock: drive at negedge, compare all outputs against the model after the edge.
    task automatic cyc(input bit v, input int x, input int c);
        @(negedge clk);
        valid_i  = v;
        data_i   = 16'(x);
        cutoff_i = 16'(c);
        model_step(v, x, c);
        @(posedge clk);
        #1;
        check("valid", longint'(valid_o), longint'(m_valid));
        check("out", longint'(out_o), longint'(m_out));
        check("settled", longint'(settled_o), longint'(m_settled));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn    = 1'b0;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_out", longint'(out_o), 0);
        check("rst_valid", longint'(valid_o), 0);
        check("rst_settled", longint'(settled_o), 0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int n;
        int guard;
        bit v;
        int c;
        rstn     = 1'b0;
        valid_i  = 1'b0;
        data_i   = '0;
        cutoff_i = '0;
        model_reset();

        // DC rejection, then cutoff change while running.
        do_reset();
        cyc(1, 500, 'h0800);
        check("dc_pre", longint'(out_o), 0);
        for (int i = 1; i <= 100; i++) begin
            cyc(1, 500, 'h0800);
            check("dc_out", longint'(out_o), 0);
            if (i == 15) check("dc_settle15", longint'(settled_o), 0);
            if (i == 16) check("dc_settle16", longint'(settled_o), 1);
        end
        cyc(1, 500, 'h1000);
        check("chg_fall", longint'(settled_o), 0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 500, 'h1000);
            if (i == 15) check("chg_settle15", longint'(settled_o), 0);
            if (i == 16) check("chg_settle16", longint'(settled_o), 1);
        end

        // Step response.
        do_reset();
        cyc(1, 0, 'h0800);
        cyc(1, 1000, 'h0800);
        check("step0", longint'(out_o), 1000);
        check("step_v", longint'(valid_o), 1);
        cyc(1, 1000, 'h0800);
        check("step1", longint'(out_o), 969);
        cyc(1, 1000, 'h0800);
        check("step2", longint'(out_o), 939);
        cyc(0, 1000, 'h0800);
        check("step_idle_v", longint'(valid_o), 0);

        // Saturation with a frozen low-pass.
        do_reset();
        cyc(1, -32768, 0);
        cyc(1, 32767, 0);
        check("sat_hi", longint'(out_o), 32767);
        cyc(1, -32768, 0);
        check("sat_zero", longint'(out_o), 0);

        // Full-duty step reference, then the same step at ~30% duty.
        do_reset();
        ref_q.delete();
        got_q.delete();
        cyc(1, 0, 'h0800);
        ref_q.push_back(int'(out_o));
        for (int i = 0; i < 39; i++) begin
            cyc(1, 1000, 'h0800);
            ref_q.push_back(int'(out_o));
        end
        do_reset();
        cyc(1, 0, 'h0800);
        got_q.push_back(int'(out_o));
        n = 1;
        guard = 0;
        while (n < 40 && guard < 2000) begin
            v = ($urandom_range(0, 99) < 30);
            cyc(v, 1000, 'h0800);
            if (valid_o) begin
                got_q.push_back(int'(out_o));
                n++;
            end
            if (!v) check("gap_no_valid", longint'(valid_o), 0);
            guard++;
        end
        check("gap_count", longint'(got_q.size()), 40);
        for (int i = 0; i < 40 && i < got_q.size(); i++) begin
            check("gap_seq", longint'(got_q[i]), longint'(ref_q[i]));
        end

        // Reset while running; the next sample must be a preload.
        do_reset();
        cyc(1, 100, 'h0800);
        for (int i = 0; i < 20; i++) cyc(1, $urandom_range(0, 4000) - 2000, 'h0800);
        check("run_settled", longint'(settled_o), 1);
        do_reset();
        cyc(1, -200, 'h0800);
        check("rst_preload_out", longint'(out_o), 0);
        check("rst_preload_v", longint'(valid_o), 1);

        // Random stream with occasional cutoff changes.
        do_reset();
        c = 'h0800;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) c = $urandom_range(0, 65535);
            cyc($urandom_range(0, 99) < 70, $urandom_range(0, 65535) - 32768, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
